// File: rtl/shift_reg_univ.sv
// WIDTH-bit universal register: hold / shift right / shift left / parallel load,
// with synchronous set and a shift counter. Optional rotate via SHIFT_REG_UNIV_ROTATE_EN.

// Next-state select for one register bit; set overrides every mode.
module shift_reg_univ_bit (
   input  logic       cur_i,
   input  logic       hi_i,
   input  logic       lo_i,
   input  logic       d_i,
   input  logic       set_val_i,
   input  logic       set_i,
   input  logic [1:0] mode_i,
   output logic       nxt_o
);
   always_comb begin
      nxt_o = cur_i;
      if (set_i) begin
         nxt_o = set_val_i;
      end else begin
         case (mode_i)
            2'b01:   nxt_o = hi_i;
            2'b10:   nxt_o = lo_i;
            2'b11:   nxt_o = d_i;
            default: nxt_o = cur_i;
         endcase
      end
   end
endmodule

module shift_reg_univ #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] SET_VAL = {WIDTH{1'b1}},
   parameter logic [WIDTH-1:0] RST_VAL = '0,
   localparam int              CW      = $clog2(WIDTH+1)
) (
`ifdef SHIFT_REG_UNIV_ROTATE_EN
   input  logic             rot,
`endif
   input  logic             clk,
   input  logic             rst,
   input  logic             set,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin_r,
   input  logic             sin_l,
   output logic [WIDTH-1:0] q,
   output logic             sout,
   output logic [CW-1:0]    cnt,
   output logic             done
);
   localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

   logic [WIDTH-1:0] q_q, q_d;
   logic             sout_q, sout_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             fill_r, fill_l;
   logic [WIDTH+1:0] ext;

`ifdef SHIFT_REG_UNIV_ROTATE_EN
   assign fill_r = rot ? q_q[0]       : sin_r;
   assign fill_l = rot ? q_q[WIDTH-1] : sin_l;
`else
   assign fill_r = sin_r;
   assign fill_l = sin_l;
`endif

   // ext[i+2] is bit i's upper neighbour, ext[i] its lower neighbour.
   assign ext = {fill_r, q_q, fill_l};

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      shift_reg_univ_bit u_bit (
         .cur_i     (q_q[i]),
         .hi_i      (ext[i+2]),
         .lo_i      (ext[i]),
         .d_i       (d[i]),
         .set_val_i (SET_VAL[i]),
         .set_i     (set),
         .mode_i    (mode),
         .nxt_o     (q_d[i])
      );
   end

   always_comb begin
      sout_d = sout_q;
      cnt_d  = cnt_q;
      done_d = 1'b0;
      if (set) begin
         cnt_d = '0;
      end else begin
         case (mode)
            2'b01, 2'b10: begin
               sout_d = (mode == 2'b01) ? q_q[0] : q_q[WIDTH-1];
               if (cnt_q == LAST) begin
                  cnt_d  = '0;
                  done_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            2'b11:   cnt_d = '0;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q    <= RST_VAL;
         sout_q <= 1'b0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         sout_q <= sout_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign q    = q_q;
   assign sout = sout_q;
   assign cnt  = cnt_q;
   assign done = done_q;
endmodule

// File: doc/shift_reg_univ.md
Name: shift_reg_univ

Overview:
- Parametrised successor to the team's single-bit set-able D flip-flop.
- WIDTH-bit universal register with four modes: hold, shift right, shift left, parallel load.
- Has a synchronous set and a shift counter that pulses `done` after WIDTH shifts.
- Serves as the serializer/deserializer element for datapath blocks in the same design.

Parameters:
- WIDTH, 8, register width in bits (>= 2).
- SET_VAL, all ones ({WIDTH{1'b1}}), value loaded by synchronous `set`.
- RST_VAL, 0, value loaded by asynchronous `rst`.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- set  input  1  synchronous set, active-high; highest synchronous priority.
- mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- d  input  WIDTH  parallel load data.
- sin_r  input  1  serial in for shift right; enters q[WIDTH-1].
- sin_l  input  1  serial in for shift left; enters q[0].
- q  output  WIDTH  register contents.
- sout  output  1  bit shifted out on the last shift: q[0] for right, q[WIDTH-1] for left.
- cnt  output  CW  shifts since last load/set/reset, where CW = $clog2(WIDTH+1).
- done  output  1  one-cycle pulse on the WIDTH-th shift.

Behaviour:
- Reset, asynchronous (`rst` = 1): immediately q=RST_VAL, sout=0, cnt=0, done=0. Held while `rst` is high.
- Priority on each rising `clk` edge when `rst` = 0: `set` > mode.
- `set` = 1: q<=SET_VAL, cnt<=0, done<=0, sout holds. `mode` is ignored, matching the original flip-flop, where set overrides d.
- mode 00: q, sout, cnt hold; done<=0.
- mode 01: q<={sin_r, q[WIDTH-1:1]}, sout<=q[0].
- mode 10: q<={q[WIDTH-2:0], sin_l}, sout<=q[WIDTH-1].
- mode 11: q<=d, cnt<=0, done<=0, sout holds.
- Counter on shift (mode 01/10):
  - If cnt==WIDTH-1: done<=1, cnt<=0 (wrap).
  - Otherwise: cnt<=cnt+1, done<=0.
- `done` is registered and high exactly one cycle, in the cycle after the WIDTH-th shift edge.
- Latency: all outputs are registered; one clock from input to q/sout/cnt/done.
- Direction may change between shifts; cnt counts shifts in either direction.
- Hold cycles do not reset cnt. A partial shift sequence resumes counting after a hold.
- Reset mid-sequence: cnt returns to 0; a pending done is dropped.
- `set` asserted in the same cycle as the WIDTH-th shift: set wins; no done pulse.
- No X propagation: unknown mode is treated as hold (default branch).

Optional Feature:
- Macro: SHIFT_REG_UNIV_ROTATE_EN.
- When defined, adds input port `rot` (1 bit). With rot=1:
  - mode 01 feeds q[0] into q[WIDTH-1] instead of sin_r.
  - mode 10 feeds q[WIDTH-1] into q[0] instead of sin_l.
  - sout and cnt behave as for a normal shift.
  - WIDTH rotates restore the original q and pulse done.
- When not defined: no `rot` port; shifts always use sin_r/sin_l.

Test Plan:
- Reset: WIDTH=8, assert rst asynchronously mid-cycle → q=0x00, cnt=0, done=0 before the next clk edge. Release, then mode=11, d=0xA5 → q=0xA5 one cycle later.
- Load then 8 right shifts with sin_r=0: q=0xA5 → serial sout sequence 1,0,1,0,0,1,0,1. q=0x00 after the 8th shift; done=1 for exactly one cycle; cnt wraps to 0.
- Left shifts, sin_l=1, from q=0x00: after 3 shifts q=0x07, cnt=3. Two hold cycles → q=0x07, cnt=3 unchanged. Then 5 more shifts → q=0xFF, done pulse.
- Set priority: set=1 with mode=11, d=0x3C → q=0xFF, cnt=0. Set on the 8th shift edge → q=0xFF, no done pulse.
- Reset mid-sequence: 4 right shifts, then pulse rst → cnt=0, q=0x00. A further 8 shifts are required before done.
- SHIFT_REG_UNIV_ROTATE_EN defined, rot=1: load 0x81, 1 right rotate → q=0xC0. 8 left rotates from 0x81 → q=0x81, done pulse.
